// File: rtl/user_counter_bank.sv
// user_counter_bank: NUM_CH independent WIDTH-bit up/down counters with
// one-shot or auto-reload behaviour, controlled over a Wishbone slave port.
// Channel 0 is mirrored on the GPIO pads and the logic-analyzer outputs,
// LA inputs can pause individual channels, and sticky terminal-count flags
// feed irq[0].
//
// Bus handshake: a request (stb & cyc & address hit) seen while ack is low
// raises ack for exactly one cycle on the next clock. Read data is valid
// only while ack is high and is zero otherwise. A write is committed at the
// end of the ack cycle, so back-to-back requests are acked every other cycle.
module user_counter_bank #(
  parameter int          NUM_CH   = 4,
  parameter int          WIDTH    = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          IO_PADS  = 38
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [127:0]       la_data_in,
  input  logic [127:0]       la_oenb,
  output logic [127:0]       la_data_out,
  input  logic [IO_PADS-1:0] io_in,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  output logic [2:0]         irq
);

  localparam int EXTW = 128 + IO_PADS;

  // CTRL field positions
  localparam int EN   = 0;
  localparam int DN   = 1;
  localparam int AR   = 2;
  localparam int IE   = 3;
  localparam int IOEN = 4;

  logic             r_ack;
  logic [4:0]       r_ctrl   [NUM_CH];
  logic [WIDTH-1:0] r_value  [NUM_CH];
  logic [WIDTH-1:0] r_reload [NUM_CH];
  logic [NUM_CH-1:0] r_tc;

  logic              w_hit;
  logic              w_req;
  logic              w_wr;
  logic [3:0]        w_ch;
  logic [1:0]        w_reg;
  logic              w_addr_ok;
  logic [31:0]       w_rd_raw;
  logic [31:0]       w_wmerge;
  logic [NUM_CH-1:0] w_wr_ch;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_cnt;
  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_ie;
  logic [EXTW-1:0]   w_ch0_ext;
  logic              w_unused;

  assign w_hit     = (wbs_adr_i[31:12] == BASE_ADR[31:12]);
  assign w_req     = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
  assign w_wr      = r_ack & wbs_stb_i & wbs_cyc_i & wbs_we_i;
  assign w_ch      = wbs_adr_i[7:4];
  assign w_reg     = wbs_adr_i[3:2];
  assign w_addr_ok = (wbs_adr_i[11:8] == 4'd0) && (int'(w_ch) < NUM_CH);

  // One-cycle ack pulse per request; ack low in between forces a gap
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_ack <= 1'b0;
    else             r_ack <= w_req;
  end

  // Register read mux; unmapped channels and addresses read as zero
  always_comb begin
    w_rd_raw = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 4'(c)) begin
        case (w_reg)
          2'd0:    w_rd_raw = 32'(r_ctrl[c]);
          2'd1:    w_rd_raw = 32'(r_value[c]);
          2'd2:    w_rd_raw = 32'(r_reload[c]);
          default: w_rd_raw = 32'(r_tc[c]);
        endcase
      end
    end
    if (!w_addr_ok) w_rd_raw = '0;
  end

  // Byte-lane merge of write data over the current register contents
  always_comb begin
    w_wmerge = w_rd_raw;
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) w_wmerge[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  // Per-channel run/terminal decode; a bus write to CTRL or VALUE suppresses
  // the count step of that channel for the cycle
  always_comb begin
    w_wr_ch = '0;
    w_run   = '0;
    w_cnt   = '0;
    w_term  = '0;
    w_ie    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_ch[c] = w_wr && w_addr_ok && (w_ch == 4'(c));
      w_run[c]   = r_ctrl[c][EN] && !(!la_oenb[c] && la_data_in[c]);
      w_cnt[c]   = w_run[c] && !(w_wr_ch[c] && (w_reg == 2'd0 || w_reg == 2'd1));
      w_term[c]  = r_ctrl[c][DN] ? (r_value[c] == '0) : (r_value[c] == r_reload[c]);
      w_ie[c]    = r_ctrl[c][IE];
    end
  end

  // Channel state: bus writes, counting, terminal handling, sticky tc
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_ctrl[c]   <= '0;
        r_value[c]  <= '0;
        r_reload[c] <= '0;
      end
      r_tc <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // CTRL: io enable exists only on channel 0
        if (w_wr_ch[c] && w_reg == 2'd0)
          r_ctrl[c] <= w_wmerge[4:0] & ((c == 0) ? 5'h1F : 5'h0F);
        else if (w_cnt[c] && w_term[c] && !r_ctrl[c][AR])
          r_ctrl[c][EN] <= 1'b0;

        // VALUE
        if (w_wr_ch[c] && w_reg == 2'd1)
          r_value[c] <= w_wmerge[WIDTH-1:0];
        else if (w_cnt[c]) begin
          if (w_term[c]) begin
            if (r_ctrl[c][AR]) r_value[c] <= r_ctrl[c][DN] ? r_reload[c] : '0;
          end else if (r_ctrl[c][DN]) begin
            r_value[c] <= r_value[c] - 1'b1;
          end else begin
            r_value[c] <= r_value[c] + 1'b1;
          end
        end

        // RELOAD
        if (w_wr_ch[c] && w_reg == 2'd2)
          r_reload[c] <= w_wmerge[WIDTH-1:0];

        // STATUS.tc: a terminal event wins over a same-cycle clear
        if (w_cnt[c] && w_term[c])
          r_tc[c] <= 1'b1;
        else if (w_wr_ch[c] && w_reg == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0])
          r_tc[c] <= 1'b0;
      end
    end
  end

  assign w_ch0_ext   = EXTW'(r_value[0]);
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_ack ? w_rd_raw : '0;
  assign la_data_out = w_ch0_ext[127:0];
  assign io_out      = w_ch0_ext[IO_PADS-1:0];
  assign io_oeb      = {IO_PADS{~r_ctrl[0][IOEN]}};
  assign irq         = {2'b00, |(r_tc & w_ie)};

  assign w_unused = ^{io_in, la_data_in, la_oenb, wbs_adr_i[1:0], w_wmerge, w_ch0_ext};

endmodule
